// File: rtl/alu_cmd_issuer.sv
// Command front-end for a combinational 4-bit ALU: accepts op commands, iterates them
// through the ALU with S fed back as A, and returns result/flags over a response handshake.
module alu_cmd_issuer #(
  parameter int DW    = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [DW-1:0]    cmd_a,
  input  logic [DW-1:0]    cmd_b,
  input  logic             cmd_use_acc,
  input  logic [CNT_W-1:0] cmd_rep,
  input  logic             acc_clr,
  output logic [DW-1:0]    alu_a,
  output logic [DW-1:0]    alu_b,
  output logic [1:0]       alu_op,
  input  logic [DW-1:0]    alu_s,
  input  logic             alu_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DW-1:0]    rsp_data,
  output logic             rsp_cout,
  output logic             rsp_zero,
  output logic [CNT_W-1:0] rsp_ccnt
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_nxt;
  logic [DW-1:0]    acc;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] ccnt;
  logic             accept;
  logic             last_iter;
  logic             carry;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != {CNT_W{1'b1}}))
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    return v;
  endfunction

  // Logic ops have no meaningful carry; only ADD/SUB (op[1]=1) propagate it.
  function automatic logic op_carry(input logic [1:0] op, input logic c);
    return op[1] & c;
  endfunction

  assign accept    = cmd_valid & cmd_ready;
  assign last_iter = (remaining == {{(CNT_W-1){1'b0}}, 1'b1});
  assign carry     = op_carry(alu_op, alu_cout);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = rst_n;
        if (cmd_valid) state_nxt = EXEC;
      end
      EXEC: if (last_iter) state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      remaining <= '0;
      ccnt      <= '0;
      rsp_data  <= '0;
      rsp_cout  <= 1'b0;
      rsp_zero  <= 1'b0;
      rsp_ccnt  <= '0;
    end else begin
      case (state)
        // Fetch: a same-edge clear wins over the accumulator read.
        IDLE: begin
          if (acc_clr) acc <= '0;
          if (accept) begin
            alu_a     <= cmd_use_acc ? (acc_clr ? '0 : acc) : cmd_a;
            alu_b     <= cmd_b;
            alu_op    <= cmd_op;
            remaining <= (cmd_rep == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : cmd_rep;
            ccnt      <= '0;
          end
        end
        // Iterate: ALU output settles within the cycle and is folded back as A.
        EXEC: begin
          acc       <= alu_s;
          alu_a     <= alu_s;
          ccnt      <= sat_inc(ccnt, carry);
          remaining <= remaining - {{(CNT_W-1){1'b0}}, 1'b1};
          if (last_iter) begin
            rsp_data <= alu_s;
            rsp_cout <= carry;
            rsp_zero <= (alu_s == '0);
            rsp_ccnt <= sat_inc(ccnt, carry);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: behavioural ALU + command-level reference model with a
// per-cycle compare process, plus directed commands with literal expectations.
module tb_alu_cmd_issuer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_use_acc, acc_clr;
  logic [1:0] cmd_op, alu_op;
  logic [3:0] cmd_a, cmd_b, cmd_rep, alu_a, alu_b, alu_s;
  logic       alu_cout;
  logic       rsp_valid, rsp_ready, rsp_cout, rsp_zero;
  logic [3:0] rsp_data, rsp_ccnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_cmd_issuer #(.DW(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc), .cmd_rep(cmd_rep),
    .acc_clr(acc_clr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_s(alu_s), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_cout(rsp_cout), .rsp_zero(rsp_zero), .rsp_ccnt(rsp_ccnt)
  );

  // 4-bit ALU: returns {cout, s}
  function automatic logic [4:0] alu5(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      2'b00:   return {1'b0, ~(a & b)};
      2'b01:   return {1'b0, ~(a | b)};
      2'b10:   return {1'b0, a} + {1'b0, b};
      default: return {1'b0, a} + {1'b0, ~b} + 5'd1;
    endcase
  endfunction

  assign {alu_cout, alu_s} = alu5(alu_op, alu_a, alu_b);

  typedef struct packed {
    logic [3:0] d;
    logic       c;
    logic [3:0] n;
  } res_t;

  function automatic res_t run_model(input logic [1:0] op, input logic [3:0] a,
                                     input logic [3:0] b, input logic [3:0] rep);
    res_t       r;
    logic [4:0] cs;
    logic [3:0] x;
    int         iters;
    x     = a;
    r     = '0;
    iters = (rep == 0) ? 1 : int'(rep);
    for (int i = 0; i < iters; i++) begin
      cs = alu5(op, x, b);
      x  = cs[3:0];
      if (cs[4] && r.n != 4'hF) r.n = r.n + 4'd1;
      r.c = cs[4];
    end
    r.d = x;
    return r;
  endfunction

  // Command-level model: idle / busy countdown / response pending
  logic [3:0] m_acc;
  res_t       m_res;
  int         m_busy;
  logic       m_resp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc  <= '0;
      m_res  <= '0;
      m_busy <= 0;
      m_resp <= 1'b0;
    end else if (m_resp) begin
      if (rsp_ready) m_resp <= 1'b0;
    end else if (m_busy != 0) begin
      m_busy <= m_busy - 1;
      if (m_busy == 1) m_resp <= 1'b1;
    end else begin
      if (acc_clr) m_acc <= '0;
      if (cmd_valid) begin
        m_res  <= run_model(cmd_op, cmd_use_acc ? (acc_clr ? 4'h0 : m_acc) : cmd_a, cmd_b, cmd_rep);
        m_acc  <= run_model(cmd_op, cmd_use_acc ? (acc_clr ? 4'h0 : m_acc) : cmd_a, cmd_b, cmd_rep).d;
        m_busy <= (cmd_rep == 0) ? 1 : int'(cmd_rep);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_cmd_ready", 32'(cmd_ready), 0);
      check("rst_outputs", {alu_a, alu_b, alu_op, rsp_valid, rsp_data, rsp_cout, rsp_zero, rsp_ccnt}, 0);
    end else begin
      check("cmd_ready", 32'(cmd_ready), 32'(!m_resp && m_busy == 0));
      check("rsp_valid", 32'(rsp_valid), 32'(m_resp));
      if (m_resp)
        check("rsp_fields", {rsp_data, rsp_cout, rsp_zero, rsp_ccnt},
              {m_res.d, m_res.c, m_res.d == 4'h0, m_res.n});
    end
  end

  task automatic wait_rsp(input string name, input int exp_lat);
    int lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, lat, exp_lat);
  endtask

  task automatic drive(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic ua, input logic [3:0] rep);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua; cmd_rep = rep; cmd_valid = 1'b1;
  endtask

  // Issue one command from IDLE, wait for its response, check literals, consume it.
  task automatic run_cmd(input string name, input logic [1:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic ua, input logic [3:0] rep,
                         input logic clr, input logic [3:0] ed, input logic ec,
                         input logic ez, input logic [3:0] en, input int elat);
    drive(op, a, b, ua, rep);
    acc_clr = clr;
    check({name, "_ready"}, 32'(cmd_ready), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0; acc_clr = 1'b0;
    wait_rsp(name, elat);
    check({name, "_data"}, 32'(rsp_data), 32'(ed));
    check({name, "_flags"}, {rsp_cout, rsp_zero, rsp_ccnt}, {ec, ez, en});
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    cmd_use_acc = 1'b0; cmd_rep = '0; acc_clr = 1'b0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_cmd("add_5_3",   2'b10, 4'h5, 4'h3, 1'b0, 4'd1, 1'b0, 4'h8, 1'b0, 1'b0, 4'd0, 1);
    run_cmd("clr_acc_x5", 2'b10, 4'h9, 4'h4, 1'b1, 4'd5, 1'b1, 4'h4, 1'b0, 1'b0, 4'd1, 5);
    run_cmd("sub_3_3",   2'b11, 4'h3, 4'h3, 1'b0, 4'd1, 1'b0, 4'h0, 1'b1, 1'b1, 4'd1, 1);
    run_cmd("nand_f_a",  2'b00, 4'hF, 4'hA, 1'b0, 4'd1, 1'b0, 4'h5, 1'b0, 1'b0, 4'd0, 1);
    run_cmd("nor_rep0",  2'b01, 4'h0, 4'h0, 1'b0, 4'd0, 1'b0, 4'hF, 1'b0, 1'b0, 4'd0, 1);
    run_cmd("sub_rep15", 2'b11, 4'h7, 4'h0, 1'b0, 4'd15, 1'b0, 4'h7, 1'b1, 1'b0, 4'd15, 15);

    // Backpressure: response held, second command waits at the source.
    rsp_ready = 1'b0;
    drive(2'b10, 4'h2, 4'h2, 1'b0, 4'd1);
    @(posedge clk); #1;
    drive(2'b10, 4'h6, 4'h1, 1'b0, 4'd2);
    wait_rsp("bp_first", 1);
    acc_clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_data", {rsp_valid, rsp_data, cmd_ready}, {1'b1, 4'h4, 1'b0});
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1; acc_clr = 1'b0;
    @(posedge clk); #1;
    check("bp_release_idle", {rsp_valid, cmd_ready}, {1'b0, 1'b1});
    @(posedge clk); #1;
    check("bp_second_accepted", 32'(cmd_ready), 0);
    cmd_valid = 1'b0;
    wait_rsp("bp_second", 2);
    check("bp_second_data", 32'(rsp_data), 32'h8);
    @(posedge clk); #1;
    run_cmd("acc_persist", 2'b10, 4'h0, 4'h0, 1'b1, 4'd1, 1'b0, 4'h8, 1'b0, 1'b0, 4'd0, 1);

    // Async reset in the middle of a long command.
    drive(2'b10, 4'h1, 4'h1, 1'b0, 4'd8);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("rst_mid_outputs", {cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_data, rsp_ccnt}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_cmd("acc_after_rst", 2'b10, 4'h0, 4'h1, 1'b1, 4'd1, 1'b0, 4'h1, 1'b0, 1'b0, 4'd0, 1);
    run_cmd("add_1_1",       2'b10, 4'h1, 4'h1, 1'b0, 4'd1, 1'b0, 4'h2, 1'b0, 1'b0, 4'd0, 1);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
